// File: rtl/bus_arbiter_if.sv
// Shared-bus bundle between the two masters (CPU datapath, host loader) and the bus arbiter.
interface bus_arbiter_if;
    logic       cpu_req;
    logic [7:0] cpu_addr;
    logic       cpu_read;
    logic       cpu_write;
    logic [7:0] cpu_wdata;
    logic       cpu_gnt;
    logic       cpu_stall;

    logic       host_req;
    logic [7:0] host_addr;
    logic       host_read;
    logic       host_write;
    logic [7:0] host_wdata;
    logic       host_gnt;

    logic [7:0] bus_addr;
    logic       bus_read;
    logic       bus_write;
    logic [7:0] bus_data;
    logic [1:0] owner;
    logic       preempt;

    // Requester side: drives requests and strobes, observes grants and the shared bus.
    modport master (
        output cpu_req, cpu_addr, cpu_read, cpu_write, cpu_wdata,
        output host_req, host_addr, host_read, host_write, host_wdata,
        input  cpu_gnt, cpu_stall, host_gnt,
        input  bus_addr, bus_read, bus_write, bus_data, owner, preempt
    );

    modport slave (
        input  cpu_req, cpu_addr, cpu_read, cpu_write, cpu_wdata,
        input  host_req, host_addr, host_read, host_write, host_wdata,
        output cpu_gnt, cpu_stall, host_gnt,
        output bus_addr, bus_read, bus_write, bus_data, owner, preempt
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master system bus arbiter with one-cycle turnaround and bounded hold time.
// Define ARB_ROUND_ROBIN_EN to break simultaneous requests in favour of the last non-owner.
module bus_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.slave  arb
);

    typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_HOST, TURN} state_t;
    typedef enum logic {OWN_CPU, OWN_HOST} last_t;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    state_t            state, next_state, tie_state;
    last_t             last_owner, last_owner_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic              preempt_q, preempt_next;
    logic              own_req, other_req;

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_state = (last_owner == OWN_HOST) ? GNT_CPU : GNT_HOST;
`else
    logic unused_last_owner;
    assign tie_state         = GNT_HOST;
    assign unused_last_owner = last_owner;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_owner <= OWN_HOST;
            preempt_q  <= 1'b0;
        end else begin
            state      <= next_state;
            hold_cnt   <= hold_next;
            last_owner <= last_owner_next;
            preempt_q  <= preempt_next;
        end
    end

    always_comb begin
        next_state      = state;
        hold_next       = hold_cnt;
        last_owner_next = last_owner;
        preempt_next    = 1'b0;
        own_req         = 1'b0;
        other_req       = 1'b0;
        case (state)
            IDLE, TURN: begin
                hold_next = '0;
                if (arb.cpu_req && arb.host_req) next_state = tie_state;
                else if (arb.cpu_req)            next_state = GNT_CPU;
                else if (arb.host_req)           next_state = GNT_HOST;
                else                             next_state = IDLE;
            end
            GNT_CPU, GNT_HOST: begin
                own_req   = (state == GNT_CPU) ? arb.cpu_req  : arb.host_req;
                other_req = (state == GNT_CPU) ? arb.host_req : arb.cpu_req;
                // The hold counter saturates, so an idle-contention grant is revoked as soon as the other side asks.
                if (!own_req || (other_req && hold_cnt == HOLD_MAX)) begin
                    next_state      = TURN;
                    hold_next       = '0;
                    preempt_next    = own_req;
                    last_owner_next = (state == GNT_CPU) ? OWN_CPU : OWN_HOST;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_next = hold_cnt + 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign arb.cpu_gnt   = (state == GNT_CPU);
    assign arb.host_gnt  = (state == GNT_HOST);
    assign arb.owner     = {state == GNT_HOST, state == GNT_CPU};
    assign arb.preempt   = preempt_q;
    assign arb.cpu_stall = arb.cpu_req & ~arb.cpu_gnt;

    always_comb begin
        arb.bus_addr  = 8'h00;
        arb.bus_read  = 1'b0;
        arb.bus_write = 1'b0;
        arb.bus_data  = 8'h00;
        case (state)
            GNT_CPU: begin
                arb.bus_addr  = arb.cpu_addr;
                arb.bus_read  = arb.cpu_read;
                arb.bus_write = arb.cpu_write;
                arb.bus_data  = arb.cpu_wdata;
            end
            GNT_HOST: begin
                arb.bus_addr  = arb.host_addr;
                arb.bus_read  = arb.host_read;
                arb.bus_write = arb.host_write;
                arb.bus_data  = arb.host_wdata;
            end
            default: ;
        endcase
    end

endmodule
